// File: rtl/probe_trace_buffer.sv
// Circular probe trace buffer: pre-trigger history plus POST_TRIG entries
// after a value/mask or external trigger, read back oldest-first.
module probe_trace_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned POST_TRIG  = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        arm,
    input  logic                        abort,
    input  logic                        cap_valid,
    input  logic [DATA_WIDTH-1:0]       cap_data,
    input  logic [DATA_WIDTH-1:0]       trig_value,
    input  logic [DATA_WIDTH-1:0]       trig_mask,
    input  logic                        trig_ext,
    input  logic [$clog2(DEPTH)-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [1:0]                  state,
    output logic [$clog2(DEPTH):0]      count,
    output logic [$clog2(DEPTH)-1:0]    trig_pos,
    output logic                        done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  st;
    logic [AW-1:0]           wp;
    logic [AW-1:0]           post_cnt;
    logic [AW-1:0]           oldest;
    logic [AW-1:0]           rd_phys;
    logic                    full;
    logic                    cap_ev;
    logic                    trig_hit;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign state    = st;
    assign done     = (st == DONE);
    assign full     = (count == CW'(DEPTH));
    assign cap_ev   = cap_valid && !abort && ((st == ARMED) || (st == POST));
    assign trig_hit = cap_ev && (st == ARMED) &&
                      ((((cap_data ^ trig_value) & trig_mask) == '0) || trig_ext);
    assign oldest   = full ? wp : '0;
    assign rd_phys  = oldest + rd_addr;

    // Trace RAM: not reset; read returns pre-write contents on a collision.
    always_ff @(posedge clk) begin
        if (cap_ev) begin
            mem[wp] <= cap_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_phys];
        end
    end

    // Capture control FSM. trig_pos tracks the trigger entry's offset from
    // the oldest entry, so it slides down whenever a post write evicts one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= IDLE;
            wp       <= '0;
            count    <= '0;
            trig_pos <= '0;
            post_cnt <= '0;
        end else if (abort) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE, DONE: begin
                    if (arm) begin
                        st       <= ARMED;
                        wp       <= '0;
                        count    <= '0;
                        post_cnt <= '0;
                    end
                end
                ARMED: begin
                    if (cap_ev) begin
                        wp <= wp + AW'(1);
                        if (!full) begin
                            count <= count + CW'(1);
                        end
                        if (trig_hit) begin
                            trig_pos <= full ? AW'(DEPTH - 1) : count[AW-1:0];
                            post_cnt <= AW'(POST_TRIG);
                            st       <= (POST_TRIG == 0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (cap_ev) begin
                        wp       <= wp + AW'(1);
                        post_cnt <= post_cnt - AW'(1);
                        if (full) begin
                            trig_pos <= trig_pos - AW'(1);
                        end else begin
                            count <= count + CW'(1);
                        end
                        if (post_cnt == AW'(1)) begin
                            st <= DONE;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_probe_trace_buffer.sv
// Directed bench for probe_trace_buffer: DEPTH=8 with POST_TRIG=2 and
// a second POST_TRIG=0 instance sharing the same stimulus.
module tb_probe_trace_buffer;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm, abort, cap_valid, trig_ext;
    logic [DW-1:0] cap_data, trig_value, trig_mask;
    logic [2:0]    rd_addr;

    logic [DW-1:0] rd_data, rd_data_z;
    logic [1:0]    state, state_z;
    logic [3:0]    count, count_z;
    logic [2:0]    trig_pos, trig_pos_z;
    logic          done, done_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    probe_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .POST_TRIG(2)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .cap_valid(cap_valid), .cap_data(cap_data), .trig_value(trig_value),
        .trig_mask(trig_mask), .trig_ext(trig_ext), .rd_addr(rd_addr),
        .rd_data(rd_data), .state(state), .count(count),
        .trig_pos(trig_pos), .done(done)
    );

    probe_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DP), .POST_TRIG(0)) dut_z (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .cap_valid(cap_valid), .cap_data(cap_data), .trig_value(trig_value),
        .trig_mask(trig_mask), .trig_ext(trig_ext), .rd_addr(rd_addr),
        .rd_data(rd_data_z), .state(state_z), .count(count_z),
        .trig_pos(trig_pos_z), .done(done_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [DW-1:0] d);
        cap_valid = 1'b1;
        cap_data  = d;
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (trig_pos !== 3'd0) begin errors++; $display("FAIL reset_trig_pos got %0d exp 0", trig_pos); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pre_wrap();
        trig_value = 32'd2;
        trig_mask  = 32'hFFFF_FFFF;
        pulse_arm();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL prewrap_armed got %0d exp 1", state); end
        cap(32'd1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL prewrap_no_trig got %0d exp 1", state); end
        cap(32'd2);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL prewrap_post got %0d exp 2", state); end
        checks++; if (trig_pos !== 3'd1) begin errors++; $display("FAIL prewrap_trig_pos_at_hit got %0d exp 1", trig_pos); end
        cap(32'd3);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL prewrap_still_post got %0d exp 2", state); end
        cap(32'd4);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL prewrap_done got %0b exp 1", done); end
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL prewrap_count got %0d exp 4", count); end
        checks++; if (trig_pos !== 3'd1) begin errors++; $display("FAIL prewrap_trig_pos got %0d exp 1", trig_pos); end
        cap(32'd5);
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL prewrap_done_ignores_cap got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 3'(i);
            tick();
            checks++;
            if (rd_data !== 32'(i + 1)) begin
                errors++; $display("FAIL prewrap_rd%0d got %0d exp %0d", i, rd_data, i + 1);
            end
        end
    endtask

    task automatic test_wrap();
        trig_value = 32'd18;
        pulse_arm();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_rearm_count got %0d exp 0", count); end
        for (int v = 1; v <= 20; v++) begin
            cap(32'(v));
            if (v == 18) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL wrap_hit_state got %0d exp 2", state); end
                checks++; if (trig_pos !== 3'd7) begin errors++; $display("FAIL wrap_hit_trig_pos got %0d exp 7", trig_pos); end
            end
        end
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL wrap_state got %0d exp 3", state); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL wrap_count got %0d exp 8", count); end
        checks++; if (trig_pos !== 3'd5) begin errors++; $display("FAIL wrap_trig_pos got %0d exp 5", trig_pos); end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
            checks++;
            if (rd_data !== 32'(13 + i)) begin
                errors++; $display("FAIL wrap_rd%0d got %0d exp %0d", i, rd_data, 13 + i);
            end
        end
    endtask

    task automatic test_trig_at_wrap();
        trig_value = 32'd8;
        pulse_arm();
        for (int v = 1; v <= 10; v++) begin
            cap(32'(v));
            if (v == 8) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL atwrap_hit_state got %0d exp 2", state); end
                checks++; if (trig_pos !== 3'd7) begin errors++; $display("FAIL atwrap_hit_trig_pos got %0d exp 7", trig_pos); end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL atwrap_done got %0b exp 1", done); end
        checks++; if (trig_pos !== 3'd5) begin errors++; $display("FAIL atwrap_trig_pos got %0d exp 5", trig_pos); end
        rd_addr = 3'd0;
        tick();
        checks++; if (rd_data !== 32'd3) begin errors++; $display("FAIL atwrap_rd0 got %0d exp 3", rd_data); end
        rd_addr = 3'd5;
        tick();
        checks++; if (rd_data !== 32'd8) begin errors++; $display("FAIL atwrap_rd5 got %0d exp 8", rd_data); end
    endtask

    task automatic test_mask_ext();
        trig_mask  = 32'h0000_00FF;
        trig_value = 32'h0000_0012;
        pulse_arm();
        trig_ext = 1'b1;
        tick();
        trig_ext = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL ext_without_cap got %0d exp 1", state); end
        cap(32'hABCD_0013);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL mask_miss got %0d exp 1", state); end
        cap(32'hABCD_0012);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL mask_hit got %0d exp 2", state); end
        checks++; if (trig_pos !== 3'd1) begin errors++; $display("FAIL mask_trig_pos got %0d exp 1", trig_pos); end
        pulse_abort();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_post got %0d exp 0", state); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL abort_keeps_count got %0d exp 2", count); end
        trig_mask  = 32'hFFFF_FFFF;
        trig_value = 32'h55;
        pulse_arm();
        trig_ext = 1'b1;
        cap(32'h99);
        trig_ext = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ext_hit got %0d exp 2", state); end
        checks++; if (trig_pos !== 3'd0) begin errors++; $display("FAIL ext_trig_pos got %0d exp 0", trig_pos); end
        pulse_abort();
    endtask

    task automatic test_post_trig_zero();
        trig_mask  = 32'hFFFF_FFFF;
        trig_value = 32'd3;
        pulse_arm();
        cap(32'd1);
        cap(32'd2);
        checks++; if (state_z !== 2'd1) begin errors++; $display("FAIL pt0_armed got %0d exp 1", state_z); end
        cap(32'd3);
        checks++; if (state_z !== 2'd3) begin errors++; $display("FAIL pt0_state got %0d exp 3", state_z); end
        checks++; if (done_z !== 1'b1) begin errors++; $display("FAIL pt0_done got %0b exp 1", done_z); end
        checks++; if (count_z !== 4'd3) begin errors++; $display("FAIL pt0_count got %0d exp 3", count_z); end
        checks++; if (trig_pos_z !== 3'd2) begin errors++; $display("FAIL pt0_trig_pos got %0d exp 2", trig_pos_z); end
        cap(32'd4);
        checks++; if (count_z !== 4'd3) begin errors++; $display("FAIL pt0_no_write got %0d exp 3", count_z); end
        rd_addr = 3'd2;
        tick();
        checks++; if (rd_data_z !== 32'd3) begin errors++; $display("FAIL pt0_rd_last got %0d exp 3", rd_data_z); end
        pulse_abort();
    endtask

    task automatic test_abort_arm();
        trig_value = 32'd99;
        pulse_arm();
        cap(32'd1);
        cap(32'd2);
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL abarm_count_pre got %0d exp 2", count); end
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL abarm_state got %0d exp 0", state); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL abarm_count_kept got %0d exp 2", count); end
        pulse_arm();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL abarm_rearm got %0d exp 1", state); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL abarm_count_clr got %0d exp 0", count); end
        cap(32'd7);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL abarm_count_one got %0d exp 1", count); end
    endtask

    task automatic test_async_reset();
        trig_value = 32'd5;
        cap(32'd5);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL areset_in_post got %0d exp 2", state); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL areset_state got %0d exp 0", state); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got %0b exp 0", done); end
        reset = 1'b0;
        cap(32'd6);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL areset_after got %0d exp 0", state); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_no_done got %0b exp 0", done); end
    endtask

    initial begin
        reset      = 1'b1;
        arm        = 1'b0;
        abort      = 1'b0;
        cap_valid  = 1'b0;
        trig_ext   = 1'b0;
        cap_data   = '0;
        trig_value = '0;
        trig_mask  = '1;
        rd_addr    = '0;
        test_reset();
        test_pre_wrap();
        test_wrap();
        test_trig_at_wrap();
        test_mask_ext();
        test_post_trig_zero();
        test_abort_arm();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
